program_sequencer: RTL

- Instruction fetch/decode/sequencing unit directly upstream of the 4-bit datapath.
- Fetches 8-bit instructions from a synchronous program ROM and decodes each into datapath controls: nibble_ir, i_sel, x_sel, y_sel, source_sel, reg_en.
- Drives sync_reset into the datapath, consumes its zero_flag for conditional jumps, and manages the program counter, including two-word jump instructions.

---
 rtl/program_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/program_sequencer.sv
// Instruction fetch/decode/sequencing unit for the 4-bit datapath.
// Walks the program ROM, decodes each word into datapath controls and resolves two-word jumps.
module program_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          pm_data,
  input  logic                zero_flag,
  output logic [PC_WIDTH-1:0] pm_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          ir,
  output logic                sync_reset,
  output logic [3:0]          nibble_ir,
  output logic                i_sel,
  output logic                x_sel,
  output logic                y_sel,
  output logic [3:0]          source_sel,
  output logic [8:0]          reg_en
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    EXEC      = 2'd1,
    TGT_FETCH = 2'd2,
    TGT_LOAD  = 2'd3
  } state_t;

  localparam logic [3:0] SRC_IDLE = 4'hA;
  localparam logic [3:0] SRC_IMM  = 4'h8;
  localparam logic [3:0] SRC_PINS = 4'h9;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] jump_tgt;
  logic [7:0]          ir_nxt;
  logic                is_jump;
  logic [2:0]          dst;
  logic [2:0]          src;

  // One-hot register enable for a 3-bit destination field; o_reg lives at bit 8
  // because bit 4 is taken by the ALU result/flag load.
  function automatic logic [8:0] dst_enable(input logic [2:0] d);
    logic [8:0] en;
    case (d)
      3'd0:    en = 9'h001;
      3'd1:    en = 9'h002;
      3'd2:    en = 9'h004;
      3'd3:    en = 9'h008;
      3'd4:    en = 9'h100;
      3'd5:    en = 9'h020;
      3'd6:    en = 9'h040;
      default: en = 9'h080;
    endcase
    return en;
  endfunction

  // Jump condition from the low bits of the latched jump opcode.
  function automatic logic jump_taken(input logic [1:0] cc, input logic zf);
    logic t;
    case (cc)
      2'b00:   t = 1'b1;
      2'b01:   t = ~zf;
      2'b10:   t = zf;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign pm_addr  = pc;
  assign pc_inc   = pc + PC_WIDTH'(1);
  assign jump_tgt = PC_WIDTH'(pm_data);
  assign is_jump  = (pm_data[7:2] == 6'b111000) && (pm_data[1:0] != 2'b11);
  assign dst      = pm_data[5:3];
  assign src      = pm_data[2:0];

  // Next-state, program counter and decoded controls
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    reg_en     = 9'h000;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    source_sel = SRC_IDLE;
    nibble_ir  = ir[3:0];

    case (state)
      FETCH: begin
        state_nxt = EXEC;
      end

      EXEC: begin
        ir_nxt    = pm_data;
        pc_nxt    = pc_inc;
        nibble_ir = pm_data[3:0];
        state_nxt = is_jump ? TGT_FETCH : FETCH;
        if (!pm_data[7]) begin
          source_sel = SRC_IMM;
          reg_en     = dst_enable(pm_data[6:4]);
        end else if (!pm_data[6]) begin
          reg_en = dst_enable(dst);
          if (dst == 3'd6 && src == 3'd6) begin
            i_sel = 1'b1;
          end else if (dst == src) begin
            source_sel = SRC_PINS;
          end else begin
            source_sel = {1'b0, src};
          end
        end else if (!pm_data[5]) begin
          x_sel  = pm_data[4];
          y_sel  = pm_data[3];
          reg_en = 9'h010;
        end
      end

      TGT_FETCH: begin
        state_nxt = TGT_LOAD;
      end

      TGT_LOAD: begin
        pc_nxt    = jump_taken(ir[1:0], zero_flag) ? jump_tgt : pc_inc;
        state_nxt = FETCH;
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase

    // The first edge out of reset is spent letting the datapath clear.
    if (sync_reset) begin
      state_nxt  = FETCH;
      pc_nxt     = pc;
      ir_nxt     = ir;
      reg_en     = 9'h000;
      i_sel      = 1'b0;
      x_sel      = 1'b0;
      y_sel      = 1'b0;
      source_sel = SRC_IDLE;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      pc         <= '0;
      ir         <= 8'h00;
      sync_reset <= 1'b1;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ir         <= ir_nxt;
      sync_reset <= 1'b0;
    end
  end

endmodule
